// File: rtl/uart_regs_pkg.sv
// Shared register-map constants and types for the UART APB register block.
// No logic: addresses, parity encoding and legal-value limits only.
// Used by the register block and available to software-model code.
package uart_regs_pkg;

    // Byte addresses of the register map (decode uses bits [7:2])
    localparam logic [7:0] ADDR_DIV      = 8'h00;
    localparam logic [7:0] ADDR_PARITY   = 8'h04;
    localparam logic [7:0] ADDR_STOP     = 8'h08;
    localparam logic [7:0] ADDR_ERR_PAR  = 8'h0C;
    localparam logic [7:0] ADDR_ERR_DROP = 8'h10;
    localparam logic [7:0] ADDR_STOP_ERR = 8'h14;
    localparam logic [7:0] ADDR_STATUS   = 8'h18;

    // Parity mode as seen by both UART halves
    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_ODD   = 2'd1,
        PAR_EVEN  = 2'd2,
        PAR_SPACE = 2'd3
    } par_mode_e;

    // Legal stop-bit counts and the smallest usable baud divider
    localparam logic [1:0]  STOP_MIN = 2'd1;
    localparam logic [1:0]  STOP_MAX = 2'd2;
    localparam int unsigned DIV_MIN  = 2;

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle (no pready/pslverr) between a bus master and the UART register block.
// Pure wiring, no latency of its own.
// No backpressure signals: every transfer is setup + access.
interface uart_apb_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata
    );
endinterface

// File: rtl/uart_apb_regs.sv
// Control/status registers for the AXI-Stream UART pair: baud divider, parity, stop bits, RX error readback.
// Writes land on the access-phase edge and drive outputs the next cycle; reads are combinational.
// No backpressure: APB3 without pready, so every transfer completes in exactly setup + access.
module uart_apb_regs
    import uart_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int unsigned DIV_RESET    = 868,
    parameter int unsigned PARITY_RESET = 0,
    parameter int unsigned STOP_RESET   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_apb_regs_if.slave        bus,
    input  logic                  tready,
    input  logic [31:0]           err_rx,
    input  logic [31:0]           err_rx_dropped,
    input  logic                  err_stop,
    output logic [DATA_WIDTH-1:0] delitel,
    output logic [DATA_WIDTH-1:0] parity_bit_mode,
    output logic [DATA_WIDTH-1:0] stop_bit_num
);

    // Word indices of each register (byte address bits [7:2])
    localparam logic [5:0] IDX_DIV      = ADDR_DIV[7:2];
    localparam logic [5:0] IDX_PARITY   = ADDR_PARITY[7:2];
    localparam logic [5:0] IDX_STOP     = ADDR_STOP[7:2];
    localparam logic [5:0] IDX_ERR_PAR  = ADDR_ERR_PAR[7:2];
    localparam logic [5:0] IDX_ERR_DROP = ADDR_ERR_DROP[7:2];
    localparam logic [5:0] IDX_STOP_ERR = ADDR_STOP_ERR[7:2];
    localparam logic [5:0] IDX_STATUS   = ADDR_STATUS[7:2];

    logic [5:0]            reg_idx;
    logic                  in_map;
    logic                  wr_stb;
    logic                  div_ok;
    logic                  stop_ok;
    logic                  unused_addr_lsb;

    logic [DATA_WIDTH-1:0] div_q;
    par_mode_e             par_q;
    logic [1:0]            stop_q;
    logic                  stop_err_q;

    // Byte lanes within a word are irrelevant; anything above bit 7 makes the access unmapped
    assign reg_idx         = bus.paddr[7:2];
    assign in_map          = (bus.paddr[ADDR_WIDTH-1:8] == '0);
    assign unused_addr_lsb = ^bus.paddr[1:0];

    assign wr_stb  = bus.psel && bus.penable && bus.pwrite && in_map;
    assign div_ok  = (bus.pwdata >= DATA_WIDTH'(DIV_MIN));
    assign stop_ok = (bus.pwdata[1:0] == STOP_MIN) || (bus.pwdata[1:0] == STOP_MAX);

    // Configuration registers; illegal divider / stop values leave the old setting in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DATA_WIDTH'(DIV_RESET);
            par_q  <= par_mode_e'(2'(PARITY_RESET));
            stop_q <= 2'(STOP_RESET);
        end else if (wr_stb) begin
            if (reg_idx == IDX_DIV && div_ok) begin
                div_q <= bus.pwdata;
            end
            if (reg_idx == IDX_PARITY) begin
                par_q <= par_mode_e'(bus.pwdata[1:0]);
            end
            if (reg_idx == IDX_STOP && stop_ok) begin
                stop_q <= bus.pwdata[1:0];
            end
        end
    end

    // Sticky stop-bit error; a new error in the clearing cycle must not be lost, so set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_err_q <= 1'b0;
        end else if (err_stop) begin
            stop_err_q <= 1'b1;
        end else if (wr_stb && reg_idx == IDX_STOP_ERR) begin
            stop_err_q <= 1'b0;
        end
    end

    assign delitel         = div_q;
    assign parity_bit_mode = {{(DATA_WIDTH-2){1'b0}}, par_q};
    assign stop_bit_num    = {{(DATA_WIDTH-2){1'b0}}, stop_q};

    // Read mux: live inputs pass straight through, bus reads zero whenever no read is selected
    always_comb begin
        bus.prdata = '0;
        if (bus.psel && !bus.pwrite && in_map) begin
            case (reg_idx)
                IDX_DIV:      bus.prdata = div_q;
                IDX_PARITY:   bus.prdata = parity_bit_mode;
                IDX_STOP:     bus.prdata = stop_bit_num;
                IDX_ERR_PAR:  bus.prdata = DATA_WIDTH'(err_rx);
                IDX_ERR_DROP: bus.prdata = DATA_WIDTH'(err_rx_dropped);
                IDX_STOP_ERR: bus.prdata = DATA_WIDTH'(stop_err_q);
                IDX_STATUS:   bus.prdata = DATA_WIDTH'(tready);
                default:      bus.prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_regs.sv
// Randomized self-checking bench for uart_apb_regs with a register-map reference model.
// Reads push expected data to a queue; a monitor pops it at each access phase.
// Control outputs are compared against the model every cycle.
module tb_uart_apb_regs;

    logic        clk;
    logic        rst_n;
    logic        tready;
    logic [31:0] err_rx;
    logic [31:0] err_rx_dropped;
    logic        err_stop;
    logic [31:0] delitel;
    logic [31:0] parity_bit_mode;
    logic [31:0] stop_bit_num;

    uart_apb_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    uart_apb_regs dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .tready          (tready),
        .err_rx          (err_rx),
        .err_rx_dropped  (err_rx_dropped),
        .err_stop        (err_stop),
        .delitel         (delitel),
        .parity_bit_mode (parity_bit_mode),
        .stop_bit_num    (stop_bit_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_div;
    int unsigned m_par;
    int unsigned m_stop;
    bit          m_sticky;

    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_div    = 868;
        m_par    = 0;
        m_stop   = 1;
        m_sticky = 0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input bit es);
        int unsigned off;
        off = a & 32'hFC;
        if ((a >> 8) == 0) begin
            case (off)
                32'h00: if (d >= 2) m_div = d;
                32'h04: m_par = d % 4;
                32'h08: if (d % 4 == 1 || d % 4 == 2) m_stop = d % 4;
                32'h14: m_sticky = 0;
                default: ;
            endcase
        end
        if (es) m_sticky = 1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if ((a >> 8) != 0) return 32'h0;
        case (a & 32'hFC)
            32'h00:  return m_div;
            32'h04:  return m_par;
            32'h08:  return m_stop;
            32'h0C:  return err_rx;
            32'h10:  return err_rx_dropped;
            32'h14:  return {31'h0, m_sticky};
            32'h18:  return {31'h0, tready};
            default: return 32'h0;
        endcase
    endfunction

    task automatic bus_idle();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input bit es);
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = a;
        bus.pwdata  = d;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        err_stop    = es;
        @(posedge clk); #1;
        model_write(a, d, es);
        err_stop = 1'b0;
        bus_idle();
    endtask

    task automatic apb_read(input logic [31:0] a);
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = a;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        exp_q.push_back(model_read(a));
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic pulse_err_stop();
        @(posedge clk); #1;
        err_stop = 1'b1;
        @(posedge clk); #1;
        m_sticky = 1;
        err_stop = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(0, 9) * 4 + $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(8, 31));
        return a;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(0, 4);
            1:       return $urandom;
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    // Monitor: read data at each access phase, idle-bus zero, control outputs vs model
    always @(negedge clk) begin
        if (bus.psel && bus.penable && !bus.pwrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", bus.prdata, 32'hDEAD_BEEF);
            end else begin
                check("prdata", bus.prdata, exp_q.pop_front());
            end
        end else if (!(bus.psel && !bus.pwrite)) begin
            check("prdata_idle_zero", bus.prdata, 32'h0);
        end
        check("delitel", delitel, m_div);
        check("parity_bit_mode", parity_bit_mode, m_par);
        check("stop_bit_num", stop_bit_num, m_stop);
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        tready         = 1'b0;
        err_rx         = 32'h0;
        err_rx_dropped = 32'h0;
        err_stop       = 1'b0;
        rst_n          = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values via readback
        apb_read(32'h00);
        apb_read(32'h04);
        apb_read(32'h08);

        // Legal writes and readback
        apb_write(32'h00, 32'd868, 1'b0);
        apb_write(32'h04, 32'd3, 1'b0);
        apb_write(32'h08, 32'd2, 1'b0);
        apb_read(32'h00);
        apb_read(32'h04);
        apb_read(32'h08);

        // Illegal writes
        apb_write(32'h00, 32'd1, 1'b0);
        apb_write(32'h08, 32'd0, 1'b0);
        apb_write(32'h08, 32'd3, 1'b0);
        apb_write(32'h04, 32'hFF, 1'b0);
        apb_read(32'h00);
        apb_read(32'h08);
        apb_read(32'h04);

        // Boundary divider value and byte-lane alias
        apb_write(32'h02, 32'd2, 1'b0);
        apb_read(32'h03);

        // Status passthrough and unmapped read
        @(posedge clk); #1;
        err_rx         = 32'd5;
        err_rx_dropped = 32'hA;
        tready         = 1'b1;
        apb_read(32'h0C);
        apb_read(32'h10);
        apb_read(32'h18);
        apb_read(32'h20);
        apb_read(32'h100);

        // Sticky stop-bit error
        pulse_err_stop();
        apb_read(32'h14);
        apb_read(32'h14);
        apb_read(32'h14);
        apb_write(32'h14, 32'h0, 1'b0);
        apb_read(32'h14);
        apb_write(32'h14, 32'h0, 1'b1);
        apb_read(32'h14);

        // Async reset during the access phase of a write
        apb_write(32'h00, 32'd500, 1'b0);
        apb_write(32'h04, 32'd2, 1'b0);
        @(posedge clk); #1;
        bus.psel   = 1'b1;
        bus.pwrite = 1'b1;
        bus.paddr  = 32'h00;
        bus.pwdata = 32'd100;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_delitel", delitel, 32'd868);
        check("async_rst_parity", parity_bit_mode, 32'd0);
        check("async_rst_stop", stop_bit_num, 32'd1);
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb_read(32'h00);
        apb_read(32'h14);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: apb_write(rand_addr(), rand_data(), 1'b0);
                4, 5, 6:    apb_read(rand_addr());
                7:          pulse_err_stop();
                8: begin
                    @(posedge clk); #1;
                    err_rx         = $urandom;
                    err_rx_dropped = $urandom;
                    tready         = 1'($urandom_range(0, 1));
                end
                default:    apb_write(rand_addr(), rand_data(), 1'b1);
            endcase
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
